// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and helpers for the multi-channel PWM
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

  // Clamp a requested duty to the full-scale value 2^cnt_w (always-active).
  function automatic logic [31:0] sat_duty(input logic [31:0] val, input int cnt_w);
    logic [31:0] full;
    full = 32'd1 << cnt_w;
    return (val > full) ? full : val;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - shared edge/centre-aligned counter with divided clock and period tick
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             center_mode,
  output logic [CNT_W-1:0] cnt,
  output logic             boundary,
  output logic             clk_div,
  output logic             period_tick
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  pwm_dir_e         dir;
  pwm_dir_e         dir_nxt;
  pwm_mode_e        mode_act;
  logic [CNT_W-1:0] cnt_nxt;
  logic             div_nxt;

  // Next-state: boundary detection, counter step/turnaround and divided-clock level.
  always_comb begin
    cnt_nxt = cnt + ONE;
    dir_nxt = dir;
    if (mode_act == PWM_CENTER) begin
      boundary = (dir == DIR_DOWN) && (cnt == ONE);
      // High for the whole up-slope except the apex: MAX of the 2*MAX cycles.
      div_nxt  = (dir == DIR_UP) && (cnt != MAX);
    end else begin
      boundary = (cnt == MAX);
      // cnt < 2^(CNT_W-1) is simply the counter MSB being clear.
      div_nxt  = !cnt[CNT_W-1];
    end
    if (boundary) begin
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
    end else if (mode_act == PWM_CENTER) begin
      if (dir == DIR_DOWN) begin
        cnt_nxt = cnt - ONE;
      end else if (cnt == MAX) begin
        cnt_nxt = cnt - ONE;
        dir_nxt = DIR_DOWN;
      end
    end
  end

  // State register; the mode only switches at a boundary so no period is truncated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      dir         <= DIR_UP;
      mode_act    <= PWM_EDGE;
      clk_div     <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      dir         <= dir_nxt;
      clk_div     <= div_nxt;
      period_tick <= boundary;
      if (boundary) begin
        mode_act <= pwm_mode_e'(center_mode);
      end
    end
  end

endmodule

// File: rtl/pwm_multi_channel.sv
// rtl/pwm_multi_channel.sv - NUM_CH PWM comparators with double-buffered duty on a shared timebase
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int NUM_CH   = 4,
  parameter int CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk_3125KHz,
  input  logic                rst_n,
  input  logic                duty_wr,
  input  logic [CH_IDX_W-1:0] duty_ch,
  input  logic [CNT_W:0]      duty_val,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic [NUM_CH-1:0]   ch_pol,
  input  logic                center_mode,
  output logic [NUM_CH-1:0]   pwm_out,
  output logic                clk_div,
  output logic                period_tick
);

  logic [CNT_W-1:0] cnt;
  logic             boundary;
  logic [CNT_W:0]   duty_sat;

  pwm_timebase #(.CNT_W(CNT_W)) u_timebase (
    .clk         (clk_3125KHz),
    .rst_n       (rst_n),
    .center_mode (center_mode),
    .cnt         (cnt),
    .boundary    (boundary),
    .clk_div     (clk_div),
    .period_tick (period_tick)
  );

  assign duty_sat = (CNT_W+1)'(sat_duty(32'(duty_val), CNT_W));

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W:0] shadow;
    logic [CNT_W:0] active;
    logic           wr_hit;
    logic           pwm_q;

    // Out-of-range channel indices never match any g, so they are dropped here.
    assign wr_hit = duty_wr && (32'(duty_ch) == g);

    // Shadow duty accepts writes at any time.
    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
      if (!rst_n) begin
        shadow <= '0;
      end else if (wr_hit) begin
        shadow <= duty_sat;
      end
    end

    // Active duty reloads at the boundary; a same-cycle write bypasses the shadow.
    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
      if (!rst_n) begin
        active <= '0;
      end else if (boundary) begin
        active <= wr_hit ? duty_sat : shadow;
      end
    end

    // Registered compare; disabled channels rest at their inactive (polarity) level.
    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
      if (!rst_n) begin
        pwm_q <= 1'b0;
      end else if (ch_en[g]) begin
        pwm_q <= ({1'b0, cnt} < active) ^ ch_pol[g];
      end else begin
        pwm_q <= ch_pol[g];
      end
    end

    assign pwm_out[g] = pwm_q;
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb/tb_pwm_multi_channel.sv - self-checking bench for pwm_multi_channel
module tb_pwm_multi_channel;

  localparam int CNT_W    = 4;
  localparam int NUM_CH   = 4;
  localparam int CH_IDX_W = 2;
  localparam int MAX      = (1 << CNT_W) - 1;
  localparam int FULL     = 1 << CNT_W;

  logic                clk_3125KHz = 1'b0;
  logic                rst_n       = 1'b1;
  logic                duty_wr     = 1'b0;
  logic [CH_IDX_W-1:0] duty_ch     = '0;
  logic [CNT_W:0]      duty_val    = '0;
  logic [NUM_CH-1:0]   ch_en       = '0;
  logic [NUM_CH-1:0]   ch_pol      = '0;
  logic                center_mode = 1'b0;
  logic [NUM_CH-1:0]   pwm_out;
  logic                clk_div;
  logic                period_tick;

  int vectors = 0;
  int errors  = 0;

  // Reference model: position within the current period, mode of that period, duties.
  int pos      = 0;
  bit m_center = 1'b0;
  int shadow[NUM_CH];
  int active[NUM_CH];

  // Per-period measurements.
  int m_hi[NUM_CH];
  int m_div;
  int m_tick;

  always #5 clk_3125KHz = ~clk_3125KHz;

  pwm_multi_channel #(.CNT_W(CNT_W), .NUM_CH(NUM_CH), .CH_IDX_W(CH_IDX_W)) dut (
    .clk_3125KHz (clk_3125KHz),
    .rst_n       (rst_n),
    .duty_wr     (duty_wr),
    .duty_ch     (duty_ch),
    .duty_val    (duty_val),
    .ch_en       (ch_en),
    .ch_pol      (ch_pol),
    .center_mode (center_mode),
    .pwm_out     (pwm_out),
    .clk_div     (clk_div),
    .period_tick (period_tick)
  );

  function automatic int period_len(bit c);
    return c ? 2 * MAX : FULL;
  endfunction

  // Counter value seen at a given position: a ramp, or a triangle in centre mode.
  function automatic int cnt_of(int p, bit c);
    return (c && p > MAX) ? 2 * MAX - p : p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pos      = 0;
    m_center = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      shadow[i] = 0;
      active[i] = 0;
    end
  endtask

  // One clock: predict registered outputs from the pre-edge state, advance model, compare.
  task automatic step();
    logic [NUM_CH-1:0] e_pwm;
    logic              e_div;
    logic              e_tick;
    int                plen;
    int                c;
    plen = period_len(m_center);
    c    = cnt_of(pos, m_center);
    for (int i = 0; i < NUM_CH; i++) begin
      e_pwm[i] = ch_en[i] ? ((c < active[i]) ^ ch_pol[i]) : ch_pol[i];
    end
    e_div  = (pos < plen / 2);
    e_tick = (pos == plen - 1);
    if (duty_wr && int'(duty_ch) < NUM_CH) begin
      shadow[duty_ch] = (int'(duty_val) > FULL) ? FULL : int'(duty_val);
    end
    if (e_tick) begin
      for (int i = 0; i < NUM_CH; i++) active[i] = shadow[i];
      m_center = center_mode;
      pos      = 0;
    end else begin
      pos++;
    end
    @(posedge clk_3125KHz);
    #1;
    chk("pwm_out", 32'(pwm_out), 32'(e_pwm));
    chk("clk_div", 32'(clk_div), 32'(e_div));
    chk("period_tick", 32'(period_tick), 32'(e_tick));
  endtask

  task automatic write(input int ch, input int v);
    duty_wr  = 1'b1;
    duty_ch  = CH_IDX_W'(ch);
    duty_val = (CNT_W+1)'(v);
    step();
    duty_wr  = 1'b0;
  endtask

  task automatic run_to_pos(input int p);
    for (int k = 0; k < 64 && pos != p; k++) step();
  endtask

  // Always crosses at least one boundary before stopping at a period start.
  task automatic run_to_start();
    step();
    for (int k = 0; k < 64 && pos != 0; k++) step();
  endtask

  // Runs one full period from its start and tallies what the DUT produced.
  task automatic measure();
    int n;
    n = period_len(m_center);
    for (int i = 0; i < NUM_CH; i++) m_hi[i] = 0;
    m_div  = 0;
    m_tick = 0;
    for (int k = 0; k < n; k++) begin
      step();
      for (int i = 0; i < NUM_CH; i++) m_hi[i] += int'(pwm_out[i]);
      m_div  += int'(clk_div);
      m_tick += int'(period_tick);
    end
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    @(posedge clk_3125KHz);
    @(posedge clk_3125KHz);
    #1;
    chk("reset_pwm", 32'(pwm_out), 32'd0);
    chk("reset_div", 32'(clk_div), 32'd0);
    chk("reset_tick", 32'(period_tick), 32'd0);
    rst_n = 1'b1;

    // Edge mode: duty 8 / 0 / 16 / 31 (saturates to 16).
    ch_en = '1;
    ch_pol = '0;
    write(0, 8);
    write(1, 0);
    write(2, 16);
    write(3, 31);
    run_to_start();
    measure();
    chk("edge_d8_hi", 32'(m_hi[0]), 32'd8);
    chk("edge_d0_hi", 32'(m_hi[1]), 32'd0);
    chk("edge_d16_hi", 32'(m_hi[2]), 32'd16);
    chk("edge_d31_hi", 32'(m_hi[3]), 32'd16);
    chk("edge_div_hi", 32'(m_div), 32'd8);
    chk("edge_ticks", 32'(m_tick), 32'd1);

    // Mid-period write takes effect next period; boundary write is forwarded.
    run_to_pos(5);
    write(0, 3);
    run_to_start();
    measure();
    chk("next_period_d3", 32'(m_hi[0]), 32'd3);
    run_to_pos(15);
    write(0, 12);
    measure();
    chk("boundary_fwd_d12", 32'(m_hi[0]), 32'd12);

    // Switch to centre mode mid-period; duty 5 gives 2*5-1 active cycles.
    run_to_pos(7);
    center_mode = 1'b1;
    write(0, 5);
    run_to_start();
    measure();
    chk("center_d5_hi", 32'(m_hi[0]), 32'd9);
    chk("center_d16_hi", 32'(m_hi[2]), 32'd30);
    chk("center_d0_hi", 32'(m_hi[1]), 32'd0);
    chk("center_div_hi", 32'(m_div), 32'd15);
    chk("center_ticks", 32'(m_tick), 32'd1);

    // Inverted polarity back in edge mode, then disable.
    center_mode = 1'b0;
    ch_pol[0] = 1'b1;
    write(0, 4);
    run_to_start();
    measure();
    chk("inv_d4_hi", 32'(m_hi[0]), 32'd12);
    ch_en[0] = 1'b0;
    step();
    chk("disabled_level", 32'(pwm_out[0]), 32'd1);

    // Randomised traffic against the model.
    for (int k = 0; k < 800; k++) begin
      duty_wr  = ($urandom_range(0, 3) == 0);
      duty_ch  = CH_IDX_W'($urandom_range(0, NUM_CH - 1));
      duty_val = (CNT_W+1)'($urandom_range(0, 2 * FULL - 1));
      if ($urandom_range(0, 15) == 0) ch_en = NUM_CH'($urandom);
      if ($urandom_range(0, 15) == 0) ch_pol = NUM_CH'($urandom);
      if ($urandom_range(0, 47) == 0) center_mode = ~center_mode;
      step();
      duty_wr = 1'b0;
    end

    // Asynchronous reset at cnt=9 with all channels driven high.
    center_mode = 1'b0;
    ch_en  = '1;
    ch_pol = '0;
    for (int i = 0; i < NUM_CH; i++) write(i, FULL);
    run_to_start();
    run_to_pos(9);
    chk("pre_reset_pwm", 32'(pwm_out), 32'hF);
    rst_n = 1'b0;
    #2;
    chk("async_reset_pwm", 32'(pwm_out), 32'd0);
    chk("async_reset_div", 32'(clk_div), 32'd0);
    chk("async_reset_tick", 32'(period_tick), 32'd0);
    model_reset();
    @(posedge clk_3125KHz);
    @(posedge clk_3125KHz);
    #1;
    rst_n = 1'b1;
    measure();
    for (int i = 0; i < NUM_CH; i++) chk("post_reset_hi", 32'(m_hi[i]), 32'd0);
    chk("post_reset_ticks", 32'(m_tick), 32'd1);
    chk("post_reset_div", 32'(m_div), 32'd8);
    write(1, 6);
    run_to_start();
    measure();
    chk("post_reset_new_d6", 32'(m_hi[1]), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
